axi4lite_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank. Generalises the fixed 2-bit-address / 8-bit-data slave to N registers of configurable width. Adds full five-channel handshakes with independent AW/W acceptance, SLVERR decode, and a flattened register output for fabric logic. Sits behind the AXI4-Lite master inside the tt_um top.

---
 rtl/axi4lite_regbank_if.sv | 70 +++++++
 rtl/axi4lite_regbank.sv | 263 ++++++++++++++++++++++++++
 tb/tb_axi4lite_regbank.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_regbank_if.sv
// -----------------------------------------------------------------------------
// axi4lite_regbank_if
//   AXI4-Lite five-channel bundle between a master and axi4lite_regbank.
//
//   Parameters : ADDR_WIDTH (byte address width), DATA_WIDTH (data width)
//   Optional   : AXIL_WSTRB_EN adds s_wstrb (one strobe bit per data byte)
//   Modports   : master drives addresses, data, valids and the response
//                readies. slave drives address/data readies and responses.
// -----------------------------------------------------------------------------
interface axi4lite_regbank_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  // Write address channel
  logic [ADDR_WIDTH-1:0]   s_awaddr;
  logic                    s_awvalid;
  logic                    s_awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   s_wdata;
`ifdef AXIL_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] s_wstrb;
`endif
  logic                    s_wvalid;
  logic                    s_wready;
  // Write response channel
  logic [1:0]              s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;
  // Read address channel
  logic [ADDR_WIDTH-1:0]   s_araddr;
  logic                    s_arvalid;
  logic                    s_arready;
  // Read data channel
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rvalid;
  logic                    s_rready;

`ifdef AXIL_WSTRB_EN
  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );
`else
  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );
`endif

endinterface

// File: rtl/axi4lite_regbank.sv
// -----------------------------------------------------------------------------
// axi4lite_regbank
//   Parametrised AXI4-Lite slave register bank: NUM_REGS registers of
//   DATA_WIDTH bits, addressed by word index addr[ADDR_WIDTH-1:log2(bytes)].
//   Indices at or beyond NUM_REGS answer SLVERR; such writes are dropped and
//   such reads return zero.
//
//   Ports
//     clk    : clock
//     rst    : asynchronous reset, active high
//     bus    : AXI4-Lite slave modport (AW, W, B, AR, R channels)
//     reg_q  : all registers flattened, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//
//   Parameters
//     ADDR_WIDTH  : byte-address width
//     DATA_WIDTH  : data width, multiple of 8, at least 8
//     NUM_REGS    : implemented registers, 1 .. 2^(word-index width)
//     RESET_VALUE : reset value of every register
//
//   Build option
//     AXIL_WSTRB_EN : when defined, s_wstrb gates each byte lane of a write;
//                     otherwise every write replaces the full word.
//
//   Write and read paths are independent FSMs. AW and W are accepted in any
//   order; the register is committed on the edge where both are held, and
//   the B response is then held until s_bready. Reads register data on the
//   AR handshake, so there is no combinational path from araddr to rdata.
// -----------------------------------------------------------------------------
module axi4lite_regbank #(
  parameter int                        ADDR_WIDTH  = 4,
  parameter int                        DATA_WIDTH  = 32,
  parameter int                        NUM_REGS    = 3,
  parameter logic [DATA_WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  axi4lite_regbank_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFFS_W;

  // One extra bit so NUM_REGS == 2^IDX_W still fits in the comparison.
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_ACCEPT, W_RESP} w_state_t;
  typedef enum logic {R_ACCEPT, R_RESP} r_state_t;

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Write path state
  // ---------------------------------------------------------------------------
  w_state_t              w_state;
  logic                  aw_captured;
  logic                  w_captured;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_ok;

  // Both flags stay set through W_RESP, so the readies are low there without
  // any extra state.
  assign bus.s_awready = !aw_captured;
  assign bus.s_wready  = !w_captured;
  assign bus.s_bvalid  = bvalid_q;
  assign bus.s_bresp   = bresp_q;

  assign aw_hs = bus.s_awvalid && !aw_captured;
  assign w_hs  = bus.s_wvalid  && !w_captured;

  // Commit once address and data are both available, whether each was
  // latched earlier or is handshaking this very cycle.
  assign commit = (w_state == W_ACCEPT)
               && (aw_captured || aw_hs)
               && (w_captured  || w_hs);

  assign wr_addr = aw_hs ? bus.s_awaddr : aw_addr_q;
  assign wr_data = w_hs  ? bus.s_wdata  : w_data_q;
  assign wr_idx  = wr_addr[ADDR_WIDTH-1:OFFS_W];
  assign wr_ok   = {1'b0, wr_idx} < NUM_REGS_L;

`ifdef AXIL_WSTRB_EN
  logic [STRB_W-1:0] w_strb_q;

  assign wr_strb = w_hs ? bus.s_wstrb : w_strb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_strb_q <= '0;
    end else if (w_hs) begin
      w_strb_q <= bus.s_wstrb;
    end
  end
`else
  assign wr_strb = '1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state     <= W_ACCEPT;
      aw_captured <= 1'b0;
      w_captured  <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (w_state)
        W_ACCEPT: begin
          if (aw_hs) begin
            aw_addr_q   <= bus.s_awaddr;
            aw_captured <= 1'b1;
          end
          if (w_hs) begin
            w_data_q   <= bus.s_wdata;
            w_captured <= 1'b1;
          end
          if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            w_state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (bus.s_bready) begin
            bvalid_q    <= 1'b0;
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            w_state     <= W_ACCEPT;
          end
        end
        default: w_state <= W_ACCEPT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this storage is a handful of control registers with a defined
      // reset value, so it is reset like ordinary flops rather than treated
      // as an uninitialised RAM.
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= RESET_VALUE;
      end
    end else if (commit && wr_ok) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_idx == IDX_W'(r)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) begin
              regs[r][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t              r_state;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  ar_hs;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_word;

  assign bus.s_arready = arready_q;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rdata   = rdata_q;
  assign bus.s_rresp   = rresp_q;

  assign ar_hs  = bus.s_arvalid && arready_q;
  assign rd_idx = bus.s_araddr[ADDR_WIDTH-1:OFFS_W];
  assign rd_ok  = {1'b0, rd_idx} < NUM_REGS_L;

  // Out-of-range indices match no entry and read as zero. The mux sees the
  // pre-edge register contents, so a read accepted on a commit edge returns
  // the old value.
  always_comb begin
    // NOTE: default first so every path assigns rd_word and no latch forms.
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_word = regs[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_ACCEPT;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_ACCEPT: begin
          if (ar_hs) begin
            rdata_q   <= rd_word;
            rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_RESP;
          end
        end
        R_RESP: begin
          if (bus.s_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_ACCEPT;
          end
        end
        default: r_state <= R_ACCEPT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Flattened register view for fabric logic
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

  // Byte-offset address bits are deliberately ignored by the decoder.
  if (OFFS_W > 0) begin : g_offset
    logic unused_offset;
    assign unused_offset = ^{wr_addr[OFFS_W-1:0], bus.s_araddr[OFFS_W-1:0]};
  end

endmodule

// File: tb/tb_axi4lite_regbank.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_regbank
//   Self-checking bench for axi4lite_regbank at default parameters
//   (ADDR_WIDTH=4, DATA_WIDTH=32, NUM_REGS=3). A table of single write/read
//   transactions with hand-computed responses and register images is played
//   first, then hand-written sequences cover out-of-order AW/W with a stalled
//   B channel, a read colliding with a commit, byte strobes (AXIL_WSTRB_EN)
//   and reset in the middle of a read.
// -----------------------------------------------------------------------------
module tb_axi4lite_regbank;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [95:0] reg_q;

  int checks   = 0;
  int failures = 0;

`ifdef AXIL_WSTRB_EN
  logic [3:0] cur_strb = 4'hF;
`endif

  axi4lite_regbank_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  axi4lite_regbank #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (32),
    .NUM_REGS   (3),
    .RESET_VALUE(32'h0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .reg_q(reg_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Simultaneous AW+W, bready held high. Checks response and B clear.
  task automatic do_write(input string tag, input logic [3:0] addr,
                          input logic [31:0] data, input logic [1:0] exp_resp);
    int n;
    @(negedge clk);
    bus.s_awaddr  = addr;
    bus.s_awvalid = 1'b1;
    bus.s_wdata   = data;
    bus.s_wvalid  = 1'b1;
    bus.s_bready  = 1'b1;
`ifdef AXIL_WSTRB_EN
    bus.s_wstrb   = cur_strb;
`endif
    n = 0;
    while (!(bus.s_awready && bus.s_wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " aw/w accepted in time"}, 96'(n < 20), 96'd1);
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    check({tag, " bvalid"}, 96'(bus.s_bvalid), 96'd1);
    check({tag, " bresp"},  96'(bus.s_bresp),  96'(exp_resp));
    @(negedge clk);
    check({tag, " bvalid cleared"}, 96'(bus.s_bvalid), 96'd0);
  endtask

  // Single read with rready held high.
  task automatic do_read(input string tag, input logic [3:0] addr,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    @(negedge clk);
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    bus.s_rready  = 1'b1;
    n = 0;
    while (!bus.s_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ar accepted in time"}, 96'(n < 20), 96'd1);
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    check({tag, " rvalid"}, 96'(bus.s_rvalid), 96'd1);
    check({tag, " rdata"},  96'(bus.s_rdata),  96'(exp_data));
    check({tag, " rresp"},  96'(bus.s_rresp),  96'(exp_resp));
    @(negedge clk);
    check({tag, " rvalid cleared"}, 96'(bus.s_rvalid), 96'd0);
  endtask

  typedef struct {
    string       name;
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;      // write data or expected read data
    logic [1:0]  resp;
    logic [95:0] exp_q;     // expected reg_q after the transaction
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{"rd0_reset",  1'b0, 4'h0, 32'h0000_0000, OKAY,   96'h0};
    vecs[1]  = '{"rd4_reset",  1'b0, 4'h4, 32'h0000_0000, OKAY,   96'h0};
    vecs[2]  = '{"rd8_reset",  1'b0, 4'h8, 32'h0000_0000, OKAY,   96'h0};
    vecs[3]  = '{"wr8",        1'b1, 4'h8, 32'hDEAD_BEEF, OKAY,
                 {32'hDEAD_BEEF, 32'h0, 32'h0}};
    vecs[4]  = '{"rd8",        1'b0, 4'h8, 32'hDEAD_BEEF, OKAY,
                 {32'hDEAD_BEEF, 32'h0, 32'h0}};
    vecs[5]  = '{"wrC_slverr", 1'b1, 4'hC, 32'hCAFE_F00D, SLVERR,
                 {32'hDEAD_BEEF, 32'h0, 32'h0}};
    vecs[6]  = '{"rdC_slverr", 1'b0, 4'hC, 32'h0000_0000, SLVERR,
                 {32'hDEAD_BEEF, 32'h0, 32'h0}};
    vecs[7]  = '{"wr1_offset", 1'b1, 4'h1, 32'hA5A5_A5A5, OKAY,
                 {32'hDEAD_BEEF, 32'h0, 32'hA5A5_A5A5}};
    vecs[8]  = '{"rd3_offset", 1'b0, 4'h3, 32'hA5A5_A5A5, OKAY,
                 {32'hDEAD_BEEF, 32'h0, 32'hA5A5_A5A5}};
    vecs[9]  = '{"wr4",        1'b1, 4'h4, 32'h0BAD_F00D, OKAY,
                 {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hA5A5_A5A5}};
    vecs[10] = '{"rd6",        1'b0, 4'h6, 32'h0BAD_F00D, OKAY,
                 {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hA5A5_A5A5}};

    bus.s_awaddr  = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b1;
    bus.s_araddr  = '0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b1;
`ifdef AXIL_WSTRB_EN
    bus.s_wstrb   = 4'hF;
`endif

    // ---- reset state -------------------------------------------------------
    #1 rst = 1'b1;
    #1;
    check("rst awready", 96'(bus.s_awready), 96'd1);
    check("rst wready",  96'(bus.s_wready),  96'd1);
    check("rst arready", 96'(bus.s_arready), 96'd1);
    check("rst bvalid",  96'(bus.s_bvalid),  96'd0);
    check("rst rvalid",  96'(bus.s_rvalid),  96'd0);
    check("rst rdata",   96'(bus.s_rdata),   96'd0);
    check("rst reg_q",   reg_q,              96'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---- table-driven single transactions -------------------------------
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr)
        do_write(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].resp);
      else
        do_read(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].resp);
      check({vecs[i].name, " reg_q"}, reg_q, vecs[i].exp_q);
    end

    // ---- W three cycles before AW, B stalled 4 cycles ---------------------
    @(negedge clk);
    bus.s_bready = 1'b0;
    bus.s_wdata  = 32'h1234_5678;
    bus.s_wvalid = 1'b1;
    @(negedge clk);                        // W handshake edge passed
    bus.s_wvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("early_w wready low",   96'(bus.s_wready),  96'd0);
      check("early_w awready high", 96'(bus.s_awready), 96'd1);
      check("early_w no bvalid",    96'(bus.s_bvalid),  96'd0);
      check("early_w reg1 old",     96'(reg_q[63:32]),  96'h0BAD_F00D);
      @(negedge clk);
    end
    bus.s_awaddr  = 4'h4;
    bus.s_awvalid = 1'b1;
    @(negedge clk);                        // commit edge passed
    bus.s_awvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("stall bvalid",  96'(bus.s_bvalid),  96'd1);
      check("stall bresp",   96'(bus.s_bresp),   96'(OKAY));
      check("stall awready", 96'(bus.s_awready), 96'd0);
      check("stall wready",  96'(bus.s_wready),  96'd0);
      @(negedge clk);
    end
    bus.s_bready = 1'b1;
    @(negedge clk);                        // B handshake edge passed
    check("after_b bvalid",  96'(bus.s_bvalid),  96'd0);
    check("after_b awready", 96'(bus.s_awready), 96'd1);
    check("after_b wready",  96'(bus.s_wready),  96'd1);
    check("after_b reg_q",   reg_q, {32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_A5A5});

    // ---- AR and write commit to the same index on one edge ----------------
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.s_awaddr  = 4'h0;
    bus.s_awvalid = 1'b1;
    bus.s_wdata   = 32'h0000_0055;
    bus.s_wvalid  = 1'b1;
`ifdef AXIL_WSTRB_EN
    bus.s_wstrb   = 4'hF;
`endif
    bus.s_araddr  = 4'h0;
    bus.s_arvalid = 1'b1;
    @(negedge clk);
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_arvalid = 1'b0;
    check("collide rvalid", 96'(bus.s_rvalid), 96'd1);
    check("collide rdata",  96'(bus.s_rdata),  96'h0);
    check("collide bvalid", 96'(bus.s_bvalid), 96'd1);
    do_read("collide_after", 4'h0, 32'h0000_0055, OKAY);

`ifdef AXIL_WSTRB_EN
    // ---- byte strobes ------------------------------------------------------
    cur_strb = 4'hF;
    do_write("strb_full", 4'h0, 32'h1122_3344, OKAY);
    cur_strb = 4'b0101;
    do_write("strb_0101", 4'h0, 32'hAABB_CCDD, OKAY);
    do_read("strb_rd", 4'h0, 32'h11BB_33DD, OKAY);
    cur_strb = 4'b0000;
    do_write("strb_none", 4'h0, 32'hFFFF_FFFF, OKAY);
    do_read("strb_none_rd", 4'h0, 32'h11BB_33DD, OKAY);
    cur_strb = 4'hF;
`endif

    // ---- reset while rvalid is held by rready=0 ---------------------------
    do_write("pre_rst_wr", 4'h8, 32'h5A5A_0F0F, OKAY);
    @(negedge clk);
    bus.s_rready  = 1'b0;
    bus.s_araddr  = 4'h8;
    bus.s_arvalid = 1'b1;
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    check("hold rvalid", 96'(bus.s_rvalid), 96'd1);
    check("hold rdata",  96'(bus.s_rdata),  96'h5A5A_0F0F);
    @(negedge clk);
    check("hold rvalid stable", 96'(bus.s_rvalid), 96'd1);
    check("hold rdata stable",  96'(bus.s_rdata),  96'h5A5A_0F0F);
    #2 rst = 1'b1;
    #1;
    check("midrst rvalid", 96'(bus.s_rvalid), 96'd0);
    check("midrst rdata",  96'(bus.s_rdata),  96'h0);
    check("midrst reg_q",  reg_q,             96'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.s_rready = 1'b1;
    @(negedge clk);
    check("post_rst arready", 96'(bus.s_arready), 96'd1);
    check("post_rst rvalid",  96'(bus.s_rvalid),  96'd0);
    check("post_rst reg_q",   reg_q,              96'h0);
    do_read("post_rst_rd", 4'h8, 32'h0, OKAY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
